// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and sizing helpers for the HUB75 frame loader
package hub75_pkg;
  typedef enum logic [1:0] {COL_R = 2'd0, COL_G = 2'd1, COL_B = 2'd2} colour_e;
  typedef enum logic [1:0] {S_LOAD, S_DONE, S_SWAP} state_e;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int words_per_frame(input int cols, input int dw, input int rows, input int planes);
    return rows * 3 * planes * (cols / dw);
  endfunction
  function automatic int addr_width(input int rows, input int halves, input int planes);
    return 1 + cw(rows / halves) + cw(planes);
  endfunction
endpackage

// File: rtl/hub75_row_bram.sv
// hub75_row_bram: simple dual-port row memory, one write port and one registered read port
//  clk/rst        clock, sync reset (clears only the read register)
//  we/waddr/wdata write port
//  re/raddr       read strobe and address; rdata updates one cycle later, holds when !re
module hub75_row_bram #(
  parameter int W  = 64,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] r_mem [2**AW];
  logic [W-1:0] r_q;
  always_ff @(posedge clk)
    if (we) r_mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (rst) r_q <= '0;
    else if (re) r_q <= r_mem[raddr];
  assign rdata = r_q;
endmodule

// File: rtl/hub75_frame_loader.sv
// hub75_frame_loader: packs a pixel-plane stream into ping-pong row BRAMs for the HUB75 scanner
//  s_valid/s_ready/s_data/s_last  input word stream, s_last marks the final word of a frame
//  rd_en/rd_row/rd_plane/rd_data  scanner read of the front bank, 1-cycle latency
//  frame_sync                     scanner frame boundary, the only moment banks may swap
//  frame_ready/front_bank/err_len back bank full, bank being scanned, sticky length error
module hub75_frame_loader
  import hub75_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int COLS       = 64,
  parameter int ROWS       = 64,
  parameter int NUM_HALVES = 2,
  parameter int PLANES     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [DATA_WIDTH-1:0]             s_data,
  input  logic                              s_last,
  input  logic                              rd_en,
  input  logic [cw(ROWS/NUM_HALVES)-1:0]    rd_row,
  input  logic [cw(PLANES)-1:0]             rd_plane,
  output logic [3*NUM_HALVES*COLS-1:0]      rd_data,
  input  logic                              frame_sync,
  output logic                              frame_ready,
  output logic                              front_bank,
  output logic                              err_len
);
  localparam int WPR    = COLS / DATA_WIDTH;
  localparam int RPH    = ROWS / NUM_HALVES;
  localparam int NUM_CH = 3 * NUM_HALVES;
  localparam int WW     = cw(WPR);
  localparam int RW     = cw(RPH);
  localparam int PW     = cw(PLANES);
  localparam int HW     = cw(NUM_HALVES);
  localparam int CHW    = cw(NUM_CH);
  localparam int AW     = addr_width(ROWS, NUM_HALVES, PLANES);
  state_e           r_state, w_next;
  logic             r_ready, r_front, r_err, r_we;
  logic [WW-1:0]    r_w;
  logic [PW-1:0]    r_p;
  colour_e          r_c;
  logic [RW-1:0]    r_r;
  logic [HW-1:0]    r_h;
  logic [COLS-1:0]  r_asm, r_wdata, w_row;
  logic [CHW-1:0]   r_wch;
  logic [AW-1:0]    r_waddr;
  logic             w_acc, w_wl, w_pl, w_cl, w_rl, w_hl, w_cnt_last, w_end;
  always_comb begin
    w_acc      = s_valid && r_ready;
    w_wl       = r_w == WW'(WPR - 1);
    w_pl       = r_p == PW'(PLANES - 1);
    w_cl       = r_c == COL_B;
    w_rl       = r_r == RW'(RPH - 1);
    w_hl       = r_h == HW'(NUM_HALVES - 1);
    w_cnt_last = w_wl && w_pl && w_cl && w_rl && w_hl;
    w_end      = w_acc && (s_last || w_cnt_last);
    w_row      = r_asm;
    w_row[r_w*DATA_WIDTH +: DATA_WIDTH] = s_data;
    w_next     = (r_state == S_LOAD) ? (w_end ? S_DONE : S_LOAD) :
                 (r_state == S_DONE) ? (frame_sync ? S_SWAP : S_DONE) : S_LOAD;
  end
  // s_ready is registered from the next state so it is low for the cycle after reset and
  // rises only the cycle after SWAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_ready <= 1'b0;
      r_front <= 1'b0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_w     <= '0;
      r_p     <= '0;
      r_c     <= COL_R;
      r_r     <= '0;
      r_h     <= '0;
      r_asm   <= '0;
      r_wdata <= '0;
      r_wch   <= '0;
      r_waddr <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= w_next == S_LOAD;
      r_we    <= w_acc && w_wl;
      if (r_state == S_DONE && frame_sync) r_front <= ~r_front;
      if (w_end && (s_last != w_cnt_last)) r_err <= 1'b1;
      if (w_acc) begin
        r_asm   <= w_row;
        r_wdata <= w_row;
        r_wch   <= CHW'(int'(r_h) * 3 + int'(r_c));
        r_waddr <= {~r_front, r_r, r_p};
        r_w     <= w_wl ? '0 : r_w + WW'(1);
        if (w_wl) r_p <= w_pl ? '0 : r_p + PW'(1);
        if (w_wl && w_pl) r_c <= w_cl ? COL_R : colour_e'(r_c + 2'd1);
        if (w_wl && w_pl && w_cl) r_r <= w_rl ? '0 : r_r + RW'(1);
        if (w_wl && w_pl && w_cl && w_rl) r_h <= w_hl ? '0 : r_h + HW'(1);
      end
      if (r_state == S_SWAP) begin
        r_w <= '0;
        r_p <= '0;
        r_c <= COL_R;
        r_r <= '0;
        r_h <= '0;
      end
    end
  end
  // Writes always target the back bank and reads the front bank, so ports never collide.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    hub75_row_bram #(.W(COLS), .AW(AW)) u_bram (
      .clk   (clk),
      .rst   (rst),
      .we    (r_we && r_wch == CHW'(i)),
      .waddr (r_waddr),
      .wdata (r_wdata),
      .re    (rd_en),
      .raddr ({r_front, rd_row, rd_plane}),
      .rdata (rd_data[i*COLS +: COLS])
    );
  end
  assign s_ready     = r_ready;
  assign frame_ready = r_state == S_DONE;
  assign front_bank  = r_front;
  assign err_len     = r_err;
endmodule
